// File: rtl/dff_row_sched.sv
// Purpose: shares one register-bank write port between requesters A/B (round-robin on ties) and runs a row-by-row clear sweep.
// Latency: Req/ClrReq sampled at edge n drive Gnt/RowEn/_RowClr in cycle n..n+1; all outputs are registered.
// Backpressure: requesters hold Req/Addr/Data until their Gnt pulse; ClrReq is held until ClrAck; writes wait out a sweep.
module dff_row_sched #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             Clk,
   input  logic             _Rst,
   input  logic             ReqA,
   input  logic [AW-1:0]    AddrA,
   input  logic [WIDTH-1:0] DataA,
   output logic             GntA,
   input  logic             ReqB,
   input  logic [AW-1:0]    AddrB,
   input  logic [WIDTH-1:0] DataB,
   output logic             GntB,
   input  logic             ClrReq,
   output logic             ClrAck,
   output logic [DEPTH-1:0] RowEn,
   output logic [WIDTH-1:0] RowD,
   output logic             _RowClr,
   output logic             Busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_SWEEP = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

   state_t           state_q,     state_d;
   logic [AW-1:0]    ptr_q,       ptr_d;
   // 1: B was the winner of the most recent tie, so A wins the next one
   logic             last_b_q,    last_b_d;
   logic             gnt_a_q,     gnt_a_d;
   logic             gnt_b_q,     gnt_b_d;
   logic             clr_ack_q,   clr_ack_d;
   logic             busy_q,      busy_d;
   logic             row_clr_n_q, row_clr_n_d;
   logic [DEPTH-1:0] row_en_q,    row_en_d;
   logic [WIDTH-1:0] row_d_q,     row_d_d;

   // One-hot row select; an address at or beyond DEPTH selects nothing, which drops the write.
   function automatic logic [DEPTH-1:0] row_sel(input logic [AW-1:0] addr);
      logic [DEPTH-1:0] sel;
      sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr == AW'(i)) begin
            sel[i] = 1'b1;
         end
      end
      return sel;
   endfunction

   // Next-state and next-output decode: arbitration in IDLE/WRITE, row walk in SWEEP, single ack in DONE.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      last_b_d    = last_b_q;
      gnt_a_d     = 1'b0;
      gnt_b_d     = 1'b0;
      clr_ack_d   = 1'b0;
      busy_d      = 1'b0;
      row_clr_n_d = 1'b1;
      row_en_d    = '0;
      row_d_d     = '0;
      case (state_q)
         ST_SWEEP: begin
            busy_d = 1'b1;
            if (ptr_q == LAST_ROW) begin
               state_d   = ST_DONE;
               ptr_d     = '0;
               clr_ack_d = 1'b1;
            end else begin
               state_d     = ST_SWEEP;
               ptr_d       = ptr_q + AW'(1);
               row_en_d    = row_sel(ptr_q + AW'(1));
               row_clr_n_d = 1'b0;
            end
         end
         ST_DONE: begin
            // Always pass through IDLE; ClrReq is still high at this edge.
            state_d = ST_IDLE;
         end
         default: begin
            if (ClrReq) begin
               state_d     = ST_SWEEP;
               ptr_d       = '0;
               row_en_d    = row_sel('0);
               row_clr_n_d = 1'b0;
               busy_d      = 1'b1;
            end else if (ReqA && (!ReqB || last_b_q)) begin
               state_d  = ST_WRITE;
               gnt_a_d  = 1'b1;
               row_en_d = row_sel(AddrA);
               row_d_d  = DataA;
               if (ReqB) begin
                  last_b_d = 1'b0;
               end
            end else if (ReqB) begin
               state_d  = ST_WRITE;
               gnt_b_d  = 1'b1;
               row_en_d = row_sel(AddrB);
               row_d_d  = DataB;
               if (ReqA) begin
                  last_b_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // State, sweep pointer, tie history and all registered outputs; reset aborts any write or sweep.
   always_ff @(posedge Clk or negedge _Rst) begin
      if (!_Rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         last_b_q    <= 1'b1;
         gnt_a_q     <= 1'b0;
         gnt_b_q     <= 1'b0;
         clr_ack_q   <= 1'b0;
         busy_q      <= 1'b0;
         row_clr_n_q <= 1'b1;
         row_en_q    <= '0;
         row_d_q     <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         last_b_q    <= last_b_d;
         gnt_a_q     <= gnt_a_d;
         gnt_b_q     <= gnt_b_d;
         clr_ack_q   <= clr_ack_d;
         busy_q      <= busy_d;
         row_clr_n_q <= row_clr_n_d;
         row_en_q    <= row_en_d;
         row_d_q     <= row_d_d;
      end
   end

   assign GntA    = gnt_a_q;
   assign GntB    = gnt_b_q;
   assign ClrAck  = clr_ack_q;
   assign Busy    = busy_q;
   assign _RowClr = row_clr_n_q;
   assign RowEn   = row_en_q;
   assign RowD    = row_d_q;

endmodule

// File: tb/tb_dff_row_sched.sv
// Bench for dff_row_sched: an 8-row and a 6-row instance side by side.
// Directed cases pin literal outputs; a random phase is checked every cycle against a schedule-level model.
// Requesters behave as the protocol expects: hold until Gnt/ClrAck seen, then drop or re-request.
`timescale 1ns/1ps
module tb_dff_row_sched;
   localparam int W  = 8;
   localparam int AW = 3;
   localparam int D0 = 8;
   localparam int D1 = 6;

   typedef struct packed {
      logic        ga;
      logic        gb;
      logic        ack;
      logic        busy;
      logic        clrn;
      logic [15:0] en;
      logic [7:0]  d;
   } exp_t;

   logic clk;
   logic rst_n;
   logic [1:0] req_a, req_b, clr_req;
   logic [1:0] gnt_a, gnt_b, clr_ack, row_clr_n, busy;
   logic [1:0][AW-1:0] addr_a, addr_b;
   logic [1:0][W-1:0]  data_a, data_b, row_d;
   logic [D0-1:0] row_en0;
   logic [D1-1:0] row_en1;
   logic [1:0][15:0] row_en;
   assign row_en = {16'(row_en1), 16'(row_en0)};

   int   total = 0;
   int   bad   = 0;
   logic checking = 1'b0;

   // model state: position inside a clear procedure (-1 none), tie history, expected outputs, banks
   int   m_pos[2];
   logic m_last_b[2];
   exp_t expv[2];
   logic [7:0] m_bank[2][16] = '{default: 8'hE5};
   logic [7:0] d_bank[2][16] = '{default: 8'hE5};

   dff_row_sched #(.WIDTH(W), .DEPTH(D0), .AW(AW)) u_d8 (
      .Clk(clk), ._Rst(rst_n),
      .ReqA(req_a[0]), .AddrA(addr_a[0]), .DataA(data_a[0]), .GntA(gnt_a[0]),
      .ReqB(req_b[0]), .AddrB(addr_b[0]), .DataB(data_b[0]), .GntB(gnt_b[0]),
      .ClrReq(clr_req[0]), .ClrAck(clr_ack[0]),
      .RowEn(row_en0), .RowD(row_d[0]), ._RowClr(row_clr_n[0]), .Busy(busy[0])
   );

   dff_row_sched #(.WIDTH(W), .DEPTH(D1), .AW(AW)) u_d6 (
      .Clk(clk), ._Rst(rst_n),
      .ReqA(req_a[1]), .AddrA(addr_a[1]), .DataA(data_a[1]), .GntA(gnt_a[1]),
      .ReqB(req_b[1]), .AddrB(addr_b[1]), .DataB(data_b[1]), .GntB(gnt_b[1]),
      .ClrReq(clr_req[1]), .ClrAck(clr_ack[1]),
      .RowEn(row_en1), .RowD(row_d[1]), ._RowClr(row_clr_n[1]), .Busy(busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int depth_of(input int i);
      return (i == 0) ? D0 : D1;
   endfunction

   function automatic exp_t idle_exp();
      exp_t e;
      e = '0;
      e.clrn = 1'b1;
      return e;
   endfunction

   // What the next cycle must look like. A clear procedure is a fixed schedule of
   // DEPTH row clears, one ack cycle and one idle cycle; otherwise the edge arbitrates.
   function automatic exp_t next_cycle(input int i);
      exp_t e;
      int   d;
      logic pick_a;
      logic pick_b;
      d = depth_of(i);
      e = idle_exp();
      pick_a = 1'b0;
      pick_b = 1'b0;
      if (m_pos[i] >= 0 && m_pos[i] <= d) begin
         m_pos[i] = m_pos[i] + 1;
         if (m_pos[i] < d) begin
            e.en = 16'd1 << m_pos[i];
            e.clrn = 1'b0;
            e.busy = 1'b1;
         end else if (m_pos[i] == d) begin
            e.ack = 1'b1;
            e.busy = 1'b1;
         end
         return e;
      end
      m_pos[i] = -1;
      if (clr_req[i]) begin
         m_pos[i] = 0;
         e.en = 16'd1;
         e.clrn = 1'b0;
         e.busy = 1'b1;
         return e;
      end
      if (req_a[i] && req_b[i]) begin
         pick_a = m_last_b[i];
         pick_b = !m_last_b[i];
         m_last_b[i] = !m_last_b[i];
      end else begin
         pick_a = req_a[i];
         pick_b = req_b[i];
      end
      if (pick_a) begin
         e.ga = 1'b1;
         e.d = data_a[i];
         if (int'(addr_a[i]) < d) e.en = 16'd1 << addr_a[i];
      end
      if (pick_b) begin
         e.gb = 1'b1;
         e.d = data_b[i];
         if (int'(addr_b[i]) < d) e.en = 16'd1 << addr_b[i];
      end
      return e;
   endfunction

   // reference model: the cycle ending at this edge updates the model bank, then the next cycle is predicted
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_pos[i] = -1;
            m_last_b[i] = 1'b1;
            expv[i] = idle_exp();
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 16; r++) begin
               if (expv[i].en[r]) m_bank[i][r] = expv[i].clrn ? expv[i].d : 8'h00;
            end
            expv[i] = next_cycle(i);
         end
      end
   end

   // register bank as driven by the DUT outputs
   always @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 16; r++) begin
               if (row_en[i][r]) d_bank[i][r] = row_clr_n[i] ? row_d[i] : 8'h00;
            end
         end
      end
   end

   task automatic chk(input string name, input int i, input logic [31:0] act_v, input logic [31:0] req_v);
      total++;
      if (act_v !== req_v) begin
         bad++;
         $display("FAIL %s inst%0d: got %h want %h at %0t", name, i, act_v, req_v, $time);
      end
   endtask

   function automatic logic [31:0] pk(input logic ga, input logic gb, input logic ack,
                                      input logic bsy, input logic clrn, input logic [15:0] en);
      return {11'd0, ga, gb, ack, bsy, clrn, en};
   endfunction

   function automatic logic [31:0] act(input int i);
      return {11'd0, gnt_a[i], gnt_b[i], clr_ack[i], busy[i], row_clr_n[i], row_en[i]};
   endfunction

   // per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (checking) begin
         for (int i = 0; i < 2; i++) begin
            chk("outputs", i, act(i), pk(expv[i].ga, expv[i].gb, expv[i].ack, expv[i].busy, expv[i].clrn, expv[i].en));
            if (expv[i].ga || expv[i].gb || !expv[i].clrn) chk("row_d", i, 32'(row_d[i]), 32'(expv[i].d));
         end
      end
   end

   task automatic wait_grant(input int i, input logic is_a, input string name);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (is_a ? gnt_a[i] : gnt_b[i]) seen = 1'b1;
      end
      if (is_a) req_a[i] = 1'b0;
      else req_b[i] = 1'b0;
      chk(name, i, 32'(seen), 32'd1);
   endtask

   task automatic drive_random(input int i, input logic allow);
      if (req_a[i] && gnt_a[i]) begin
         if (allow && $urandom_range(0, 3) == 0) begin
            addr_a[i] = AW'($urandom_range(0, 7));
            data_a[i] = W'($urandom);
         end else begin
            req_a[i] = 1'b0;
         end
      end else if (!req_a[i] && allow && $urandom_range(0, 2) == 0) begin
         req_a[i] = 1'b1;
         addr_a[i] = AW'($urandom_range(0, 7));
         data_a[i] = W'($urandom);
      end
      if (req_b[i] && gnt_b[i]) begin
         if (allow && $urandom_range(0, 3) == 0) begin
            addr_b[i] = AW'($urandom_range(0, 7));
            data_b[i] = W'($urandom);
         end else begin
            req_b[i] = 1'b0;
         end
      end else if (!req_b[i] && allow && $urandom_range(0, 2) == 0) begin
         req_b[i] = 1'b1;
         addr_b[i] = AW'($urandom_range(0, 7));
         data_b[i] = W'($urandom);
      end
      if (clr_req[i] && clr_ack[i]) clr_req[i] = 1'b0;
      else if (!clr_req[i] && allow && $urandom_range(0, 39) == 0) clr_req[i] = 1'b1;
   endtask

   initial begin
      int   ack_at;
      int   gnt_at;
      int   sweeps;
      logic found;
      rst_n = 1'b0;
      req_a = '0; req_b = '0; clr_req = '0;
      addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
      repeat (3) @(negedge clk);
      checking = 1'b1;

      // reset values, held and just after release
      chk("reset_hold", 0, act(0), pk(0, 0, 0, 0, 1, 16'h0));
      chk("reset_hold_d", 0, 32'(row_d[0]), 32'h0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_release", 1, act(1), pk(0, 0, 0, 0, 1, 16'h0));

      // contention straight after reset: A first, then strict alternation
      req_a[0] = 1'b1; addr_a[0] = 3'd1; data_a[0] = 8'h11;
      req_b[0] = 1'b1; addr_b[0] = 3'd2; data_b[0] = 8'h22;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k % 2 == 0) chk("contention", 0, act(0), pk(1, 0, 0, 0, 1, 16'h02));
         else            chk("contention", 0, act(0), pk(0, 1, 0, 0, 1, 16'h04));
         chk("contention_d", 0, 32'(row_d[0]), (k % 2 == 0) ? 32'h11 : 32'h22);
      end
      req_a[0] = 1'b0; req_b[0] = 1'b0;
      @(negedge clk);
      chk("contention_end", 0, act(0), pk(0, 0, 0, 0, 1, 16'h0));

      // single write
      req_a[0] = 1'b1; addr_a[0] = 3'd5; data_a[0] = 8'hA5;
      @(negedge clk);
      chk("single", 0, act(0), pk(1, 0, 0, 0, 1, 16'h20));
      chk("single_d", 0, 32'(row_d[0]), 32'hA5);
      req_a[0] = 1'b0;
      @(negedge clk);
      chk("single_idle", 0, act(0), pk(0, 0, 0, 0, 1, 16'h0));

      // full sweep from idle
      clr_req[0] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("sweep_row", 0, act(0), pk(0, 0, 0, 1, 0, 16'd1 << k));
      end
      @(negedge clk);
      chk("sweep_ack", 0, act(0), pk(0, 0, 1, 1, 1, 16'h0));
      clr_req[0] = 1'b0;
      @(negedge clk);
      chk("sweep_after", 0, act(0), pk(0, 0, 0, 0, 1, 16'h0));

      // clear and write rising together: sweep first, grant two cycles after the ack
      clr_req[0] = 1'b1; req_b[0] = 1'b1; addr_b[0] = 3'd3; data_b[0] = 8'h3C;
      ack_at = -1; gnt_at = -1; sweeps = 0;
      for (int c = 0; c < 30 && gnt_at < 0; c++) begin
         @(negedge clk);
         if (row_en[0] != 16'h0 && !row_clr_n[0]) sweeps++;
         if (clr_ack[0]) begin ack_at = c; clr_req[0] = 1'b0; end
         if (gnt_b[0]) begin gnt_at = c; req_b[0] = 1'b0; end
      end
      req_b[0] = 1'b0; clr_req[0] = 1'b0;
      chk("collision_rows", 0, 32'(sweeps), 32'd8);
      chk("collision_ack_cycle", 0, 32'(ack_at), 32'd8);
      chk("collision_gap", 0, 32'(gnt_at - ack_at), 32'd2);

      // reset during a grant cycle: the held request is granted after release
      @(negedge clk);
      req_a[0] = 1'b1; addr_a[0] = 3'd6; data_a[0] = 8'h66;
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("reset_midwrite", 0, act(0), pk(0, 0, 0, 0, 1, 16'h0));
      #2 rst_n = 1'b1;
      wait_grant(0, 1'b1, "regrant_after_reset");

      // out-of-range address on the 6-row instance
      @(negedge clk);
      req_a[1] = 1'b1; addr_a[1] = 3'd7; data_a[1] = 8'h77;
      @(negedge clk);
      chk("oor", 1, act(1), pk(1, 0, 0, 0, 1, 16'h0));
      chk("oor_d", 1, 32'(row_d[1]), 32'h77);
      req_a[1] = 1'b0;

      // fill the 6 rows, then abort a sweep at row 3 with reset
      for (int r = 0; r < 6; r++) begin
         req_a[1] = 1'b1; addr_a[1] = AW'(r); data_a[1] = 8'h10 + 8'(r);
         wait_grant(1, 1'b1, "fill");
      end
      @(negedge clk);
      clr_req[1] = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 12 && !found; c++) begin
         @(negedge clk);
         if (row_en[1] == 16'h08) found = 1'b1;
      end
      chk("sweep_row3_reached", 1, 32'(found), 32'd1);
      #2 rst_n = 1'b0;
      clr_req[1] = 1'b0;
      @(negedge clk);
      chk("sweep_abort", 1, act(1), pk(0, 0, 0, 0, 1, 16'h0));
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("sweep_abort_idle", 1, act(1), pk(0, 0, 0, 0, 1, 16'h0));
      for (int r = 0; r < 6; r++) begin
         chk("bank_after_abort", 1, 32'(d_bank[1][r]), (r < 3) ? 32'h0 : 32'h10 + 32'(r));
      end

      // random traffic on both instances, then a quiet tail to drain held requests
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) drive_random(i, cyc < 2880);
      end
      for (int i = 0; i < 2; i++) begin
         chk("drained", i, 32'({req_a[i], req_b[i], clr_req[i]}), 32'd0);
         for (int r = 0; r < depth_of(i); r++) begin
            chk("bank", i, 32'(d_bank[i][r]), 32'(m_bank[i][r]));
         end
      end

      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dff_row_sched.md
# dff_row_sched

Scheduler for a bank of DEPTH word registers built from synchronous-clear D flip-flop rows. It shares the bank's single write port between two requesters (A, B) with round-robin arbitration. It also runs a bank-wide clear sweep that walks every row with the row clear line low. It sits between the requesting datapath blocks and the row enable / data / clear nets of the register bank.

## Interface
Parameters:
- WIDTH, 8, bits per row (width of RowD).
- DEPTH, 8, number of rows, 2..16.
- AW, 3, address width; 2^AW >= DEPTH.

Ports:
- Clk  in  1  single clock; all state changes on rising edge.
- _Rst  in  1  asynchronous, active-low reset.
- ReqA  in  1  write request from A; held with AddrA/DataA until GntA.
- AddrA  in  AW  target row for A.
- DataA  in  WIDTH  write data for A.
- GntA  out  1  one-cycle grant pulse for A.
- ReqB, AddrB, DataB, GntB  same as the A set, for requester B.
- ClrReq  in  1  level request to clear the whole bank; held until ClrAck.
- ClrAck  out  1  one-cycle pulse when the sweep completes.
- RowEn  out  DEPTH  one-hot row capture qualifier; all zero means no row is written.
- RowD  out  WIDTH  data to the D pins of the enabled row.
- _RowClr  out  1  drives the _Clr of the enabled row; 0 means the row captures 0.
- Busy  out  1  high while a sweep is in progress (SWEEP or DONE).

## Operation
- All outputs are registered. Row i captures RowD, or 0 when _RowClr=0, at the rising Clk edge that ends a cycle with RowEn[i]=1.
- FSM states: IDLE, WRITE, SWEEP, DONE.
- Arbitration runs at every edge where the state is IDLE or WRITE. Priority order:
  - ClrReq=1: go to SWEEP with Ptr=0.
  - Otherwise, exactly one of ReqA/ReqB high: grant it.
  - Otherwise, both high: grant the one not recorded in Last, then update Last.
  - Otherwise, nothing requested: go to IDLE.
- WRITE cycle:
  - GntX=1, RowEn=onehot(AddrX), RowD=DataX, _RowClr=1.
  - AddrX and DataX are captured at the arbitration edge.
  - If AddrX >= DEPTH, the grant is still issued but RowEn is all zero (write dropped).
- SWEEP cycle: RowEn=onehot(Ptr), _RowClr=0, RowD=0, no grants. Ptr increments each cycle. After Ptr=DEPTH-1 the next state is DONE.
- DONE: one cycle with ClrAck=1, RowEn=0, no grants; the next state is IDLE unconditionally. The requester drops ClrReq at the edge where it sees ClrAck.
- Write requests arriving during SWEEP/DONE wait; they are not lost because requesters hold them.
- A requester that keeps Req high after its grant is treated as a new request.
- IDLE: RowEn=0, _RowClr=1, Gnt*=0, ClrAck=0.

## Timing
- Reset (async assert, removal synchronized by design): state IDLE; RowEn=0, RowD=0, _RowClr=1, GntA=GntB=0, ClrAck=0, Busy=0; Ptr=0; Last=B, so A wins the first tie.
- Write latency: Req sampled at edge n gives Gnt/RowEn high in cycle n..n+1; the row updates at edge n+1.
- Throughput: one write per cycle, since back-to-back WRITE states are allowed. Two continuous requesters alternate A,B,A,B.
- Sweep: ClrReq sampled at edge n, SWEEP for DEPTH cycles, DONE in the next cycle. ClrAck is high DEPTH+1 cycles after the sampling edge. Busy is high for DEPTH+1 cycles.
- ClrReq rising in the same cycle as ReqA/ReqB: the sweep wins and the writes are granted after DONE+IDLE arbitration.
- Reset mid-sweep: aborts immediately with no ClrAck. Rows not yet swept keep their contents; the requester must re-request.
- Reset mid-write: the pending grant is lost; the requester still holds Req and is granted after reset.

## Test plan
- Reset: drive _Rst=0 mid-operation, then release -> RowEn=0, _RowClr=1, GntA=GntB=0, ClrAck=0, Busy=0 immediately and after release.
- Single write: ReqA=1, AddrA=5, DataA=0xA5 -> GntA=1, RowEn=8'b0010_0000, RowD=0xA5, _RowClr=1 one cycle after sampling; IDLE after ReqA drops.
- Contention: ReqA and ReqB held high for 6 cycles (AddrA=1, AddrB=2) -> grants A,B,A,B,A,B; RowEn alternates 0x02/0x04; never both grants high.
- Sweep: ClrReq=1 from IDLE (DEPTH=8) -> RowEn walks 0x01..0x80 with _RowClr=0 for 8 cycles, then ClrAck=1 for one cycle; Busy high for 9 cycles.
- Clear vs write collision: ClrReq and ReqB rise in the same cycle -> full 8-row sweep and ClrAck first, then GntB two cycles after ClrAck.
- Out-of-range and mid-sweep reset: DEPTH=6 with AddrA=7 -> GntA=1 and RowEn=0. _Rst pulsed at sweep row 3 -> no ClrAck, state IDLE, rows 4..5 untouched.
